// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Program-level controller for the instruction fetch stage. It runs the
// bench Start/Done handshake, selects the start address of the current
// program (0, 1, 2 in series), drives load/hold controls into the PC
// register, detects halt and enforces a watchdog limit on RUN cycles.
// Branch handling stays inside the PC; this block only loads or freezes it.
//
// Optional build macro: FETCH_SEQ_CYCLE_CNT_EN
//   defined   : CycleCnt counts RUN cycles (saturating), frozen in DONE,
//               cleared in ARM.
//   undefined : no counter logic, CycleCnt is constant 0.
//   Watchdog, Done and Timeout behave identically in both builds.
//
// Ports:
//   Clk        in   clock, all state changes on posedge
//   Reset      in   asynchronous active-high reset
//   Start      in   bench request; held high while arming, program runs
//                   after it is released
//   HaltDet    in   decoder flags the fetched instruction as halt
//   PcLoad     out  PC loads PcLoadVal this cycle
//   PcLoadVal  out  [T-1:0] start address of the current program
//   PcHold     out  PC holds its value (overrides increment/branch)
//   Done       out  program finished; level until the next Start
//   Timeout    out  last program was ended by the watchdog
//   ProgIdx    out  [1:0] index of the current/next program
//   CycleCnt   out  [CW-1:0] RUN cycles of the last/current program
//   DbgState   out  [1:0] FSM state (0 IDLE, 1 ARM, 2 RUN, 3 DONE)
//
// Handshake: Start is a level request, not a valid/ready pair. While Start
// is high the sequencer sits in ARM and reloads the PC every cycle; the
// program begins on the cycle Start is seen low. Done is a level that
// stays high until the next Start is accepted. HaltDet is only sampled
// in RUN.
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int T        = 10,
  parameter int NPROG    = 3,
  parameter int START0   = 0,
  parameter int START1   = 'h100,
  parameter int START2   = 'h200,
  parameter int WDOG_MAX = 4095,
  parameter int CW       = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          HaltDet,
  output logic          PcLoad,
  output logic [T-1:0]  PcLoadVal,
  output logic          PcHold,
  output logic          Done,
  output logic          Timeout,
  output logic [1:0]    ProgIdx,
  output logic [CW-1:0] CycleCnt,
  output logic [1:0]    DbgState
);

  localparam int WD_W = $clog2(WDOG_MAX + 1);

  localparam logic [T-1:0]    START0_V = T'(START0);
  localparam logic [T-1:0]    START1_V = T'(START1);
  localparam logic [T-1:0]    START2_V = T'(START2);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(WDOG_MAX - 1);
  localparam logic [WD_W-1:0] WD_SAT   = WD_W'(WDOG_MAX);
  localparam logic [1:0]      IDX_LAST = 2'(NPROG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state, state_nxt;

  logic            pc_load,  pc_load_nxt;
  logic            pc_hold,  pc_hold_nxt;
  logic            done,     done_nxt;
  logic            timeout,  timeout_nxt;
  logic [1:0]      prog_idx, prog_idx_nxt;
  logic [WD_W-1:0] wdog,     wdog_nxt;

  logic            wd_expire;

  assign wd_expire = (wdog == WD_LAST);

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      pc_load  <= 1'b0;
      pc_hold  <= 1'b1;
      done     <= 1'b0;
      timeout  <= 1'b0;
      prog_idx <= 2'd0;
      wdog     <= '0;
    end else begin
      state    <= state_nxt;
      pc_load  <= pc_load_nxt;
      pc_hold  <= pc_hold_nxt;
      done     <= done_nxt;
      timeout  <= timeout_nxt;
      prog_idx <= prog_idx_nxt;
      wdog     <= wdog_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (Start) state_nxt = S_ARM;
      S_ARM:  if (!Start) state_nxt = S_RUN;
      S_RUN: begin
        // Halt beats both restart and watchdog expiry in the same cycle.
        if (HaltDet)        state_nxt = S_DONE;
        else if (Start)     state_nxt = S_ARM;
        else if (wd_expire) state_nxt = S_DONE;
      end
      S_DONE: if (Start) state_nxt = S_ARM;
      default: state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: computes the values the output registers take on the
  // coming edge, so every output lines up with the state it belongs to.
  // -------------------------------------------------------------------------
  always_comb begin
    pc_load_nxt  = (state_nxt == S_ARM);
    pc_hold_nxt  = (state_nxt == S_IDLE) || (state_nxt == S_DONE);
    done_nxt     = done;
    timeout_nxt  = timeout;
    prog_idx_nxt = prog_idx;
    wdog_nxt     = wdog;

    if ((state == S_RUN) && (wdog != WD_SAT)) begin
      wdog_nxt = wdog + 1'b1;
    end

    if ((state == S_RUN) && (state_nxt == S_DONE)) begin
      done_nxt     = 1'b1;
      // Reaching DONE without HaltDet can only be the watchdog.
      timeout_nxt  = !HaltDet;
      prog_idx_nxt = (prog_idx == IDX_LAST) ? 2'd0 : prog_idx + 2'd1;
    end

    if (state_nxt == S_ARM) begin
      done_nxt    = 1'b0;
      timeout_nxt = 1'b0;
      wdog_nxt    = '0;
    end
  end

  // Start address decode; indices >= NPROG never occur.
  always_comb begin
    case (prog_idx)
      2'd0:    PcLoadVal = START0_V;
      2'd1:    PcLoadVal = START1_V;
      default: PcLoadVal = START2_V;
    endcase
  end

`ifdef FETCH_SEQ_CYCLE_CNT_EN
  logic [CW-1:0] cyc_cnt;

  // Cleared whenever ARM is entered (also on restart from RUN), counts
  // every RUN cycle including the one that ends the program, then holds.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cyc_cnt <= '0;
    end else if (state_nxt == S_ARM) begin
      cyc_cnt <= '0;
    end else if ((state == S_RUN) && (cyc_cnt != {CW{1'b1}})) begin
      cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

  assign CycleCnt = cyc_cnt;
`else
  assign CycleCnt = '0;
`endif

  assign PcLoad   = pc_load;
  assign PcHold   = pc_hold;
  assign Done     = done;
  assign Timeout  = timeout;
  assign ProgIdx  = prog_idx;
  assign DbgState = state;

endmodule
